// File: rtl/cla_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : cla_sub_pipe
// Purpose  : Pipelined WIDTH-bit subtractor computing (A - B - Bin) mod 2^WIDTH.
//            Each pipeline stage resolves one SLICE-bit borrow-lookahead
//            slice. The slice borrow-out is registered and feeds the next
//            stage. A valid/ready handshake uses a global stall.
// Ports    : clk, rst (sync, active-high)
//            in_valid / in_ready  - operand beat handshake (A, B, Bin)
//            out_valid / out_ready - result beat handshake
//            Diff  - difference
//            Bout  - unsigned borrow-out (A < B + Bin)
//            Ovf   - signed overflow
//            Zero  - Diff == 0
// Revision : 1.0 - initial release
// ============================================================================
module cla_sub_pipe #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic             Ovf,
    output logic             Zero
);

    // Guarded divisor so a bad SLICE reaches the check below instead of
    // tripping a divide-by-zero first.
    localparam int c_slice  = (SLICE < 1) ? 1 : SLICE;
    localparam int c_stages = WIDTH / c_slice;

    if ((SLICE < 1) || (c_stages < 1) || ((WIDTH % c_slice) != 0)) begin : g_param_check
        $error("cla_sub_pipe: WIDTH must be a positive integer multiple of SLICE");
    end

    // One borrow-lookahead slice. Every internal borrow is a flat
    // sum-of-products of generate/propagate terms rather than a ripple chain:
    //   b[i+1] = g[i] | p[i]g[i-1] | ... | p[i]..p[0]bin
    // Returns {borrow_out, diff}.
    function automatic logic [SLICE:0] slice_sub(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             bin
    );
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] p;
        logic [SLICE:0]   brw;
        logic             term;
        g      = ~a & b;
        p      = ~(a ^ b);
        brw    = '0;
        brw[0] = bin;
        for (int i = 0; i < SLICE; i++) begin
            term = bin;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            brw[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                brw[i+1] = brw[i+1] | term;
            end
        end
        return {brw[SLICE], a ^ b ^ brw[SLICE-1:0]};
    endfunction

    logic w_stall;
    logic w_accept;

    // Global stall: only a held result blocks the pipe; bubbles still advance.
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;
    assign w_accept = in_valid & in_ready;

    // Stage k holds the low k slices of the difference, the operand bits not
    // yet resolved, and the borrow pending into slice k.
    for (genvar k = 1; k <= c_stages; k++) begin : g_stage
        localparam int c_lo = (k - 1) * SLICE;  // first bit resolved entering this stage
        localparam int c_dw = k * SLICE;        // resolved difference width held here
        localparam int c_sw = WIDTH - c_lo;     // unresolved operand width arriving

        logic              w_src_vld;
        logic              w_src_brw;
        logic [c_sw-1:0]   w_src_a;
        logic [c_sw-1:0]   w_src_b;
        logic [SLICE:0]    w_res;
        logic [c_dw-1:0]   w_nxt_diff;
        logic              r_vld;
        logic              r_brw;
        logic [c_dw-1:0]   r_diff;

        if (k == 1) begin : g_src_in
            assign w_src_vld  = w_accept;
            assign w_src_brw  = Bin;
            assign w_src_a    = A;
            assign w_src_b    = B;
            assign w_nxt_diff = w_res[SLICE-1:0];
        end else begin : g_src_stg
            assign w_src_vld  = g_stage[k-1].r_vld;
            assign w_src_brw  = g_stage[k-1].r_brw;
            assign w_src_a    = g_stage[k-1].g_opnd.r_a;
            assign w_src_b    = g_stage[k-1].g_opnd.r_b;
            assign w_nxt_diff = {w_res[SLICE-1:0], g_stage[k-1].r_diff};
        end

        assign w_res = slice_sub(w_src_a[SLICE-1:0], w_src_b[SLICE-1:0], w_src_brw);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_vld  <= 1'b0;
                r_brw  <= 1'b0;
                r_diff <= '0;
            end else if (!w_stall) begin
                r_vld  <= w_src_vld;
                r_brw  <= w_res[SLICE];
                r_diff <= w_nxt_diff;
            end
        end

        // Operand bits above the slice just resolved travel with the beat.
        if (k < c_stages) begin : g_opnd
            logic [c_sw-SLICE-1:0] r_a;
            logic [c_sw-SLICE-1:0] r_b;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (!w_stall) begin
                    r_a <= w_src_a[c_sw-1:SLICE];
                    r_b <= w_src_b[c_sw-1:SLICE];
                end
            end
        end

        // Flags are formed while the top slice resolves, so the output
        // register carries them alongside Diff with no logic after it.
        if (k == c_stages) begin : g_flags
            logic r_ovf;
            logic r_zero;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (!w_stall) begin
                    r_ovf  <= (w_src_a[SLICE-1] ^ w_src_b[SLICE-1]) &
                              (w_res[SLICE-1] ^ w_src_a[SLICE-1]);
                    r_zero <= ~|w_nxt_diff;
                end
            end
        end
    end

    assign out_valid = g_stage[c_stages].r_vld;
    assign Diff      = g_stage[c_stages].r_diff;
    assign Bout      = g_stage[c_stages].r_brw;
    assign Ovf       = g_stage[c_stages].g_flags.r_ovf;
    assign Zero      = g_stage[c_stages].g_flags.r_zero;

endmodule
`default_nettype wire

// File: tb/tb_cla_sub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_cla_sub_pipe
// Purpose  : Self-checking bench for cla_sub_pipe (WIDTH=32, SLICE=8):
//            directed vectors, a 16-beat stream under random back-pressure,
//            and a mid-stream reset flush.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cla_sub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        Bin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Diff;
    logic        Bout;
    logic        Ovf;
    logic        Zero;

    int total = 0;
    int bad   = 0;

    cla_sub_pipe #(.WIDTH(32), .SLICE(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Diff      (Diff),
        .Bout      (Bout),
        .Ovf       (Ovf),
        .Zero      (Zero)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: {bout, ovf, zero, diff} from plain 33-bit arithmetic.
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic bin);
        logic [32:0] t;
        logic        ov;
        t  = {1'b0, a} - {1'b0, b} - {32'd0, bin};
        ov = (a[31] != b[31]) && (t[31] != a[31]);
        return {t[32], ov, (t[31:0] == 32'd0), t[31:0]};
    endfunction

    // Single beat on an idle pipe; checks 4-edge latency and all result fields.
    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic bin, input logic [31:0] ed, input logic eb,
                           input logic eo, input logic ez);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A = a; B = b; Bin = bin;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = '0; B = '0; Bin = 1'b0;
        for (int e = 1; e < 4; e++) begin
            check({tag, "_early"}, out_valid, 0);
            @(posedge clk); #1;
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_diff"}, Diff, ed);
        check({tag, "_bout"}, Bout, eb);
        check({tag, "_ovf"}, Ovf, eo);
        check({tag, "_zero"}, Zero, ez);
        @(posedge clk); #1;
        check({tag, "_drain"}, out_valid, 0);
    endtask

    logic [34:0] q[$];
    logic [3:0]  mv;
    logic        exp_stall;
    logic [31:0] cur_a;
    logic [31:0] cur_b;
    logic        cur_bin;
    int          sent;
    int          recv;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Bin = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", Diff, 0);
        check("rst_bout", Bout, 0);
        check("rst_ovf", Ovf, 0);
        check("rst_zero", Zero, 0);
        check("rst_in_ready", in_ready, 1);

        run_one("zero",     32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_one("under",    32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_one("xslice",   32'h0100_0000, 32'h0000_0001, 1'b0, 32'h00FF_FFFF, 1'b0, 1'b0, 1'b0);
        run_one("binzero",  32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
        run_one("ovf_neg",  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
        run_one("ovf_both", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
        run_one("bin_only", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_one("max_bin",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b1 & 1'b0, 1'b0);

        // Stream of 16 beats under random back-pressure against a valid-bit
        // occupancy model and a result queue.
        mv = '0; sent = 0; recv = 0;
        cur_a = $urandom(); cur_b = $urandom(); cur_bin = 1'($urandom_range(0, 1));
        for (int cyc = 0; cyc < 400 && recv < 16; cyc++) begin
            out_ready = ($urandom_range(0, 2) != 0);
            in_valid  = (sent < 16);
            A = cur_a; B = cur_b; Bin = cur_bin;
            #1;
            exp_stall = mv[3] & ~out_ready;
            check("s_in_ready", in_ready, !exp_stall);
            check("s_out_valid", out_valid, mv[3]);
            if (mv[3] && q.size() > 0)
                check("s_result", {Bout, Ovf, Zero, Diff}, q[0]);
            if (!exp_stall) begin
                if (mv[3] && q.size() > 0) begin
                    void'(q.pop_front());
                    recv++;
                end
                if (in_valid) begin
                    q.push_back(model(cur_a, cur_b, cur_bin));
                    sent++;
                    cur_a = $urandom(); cur_b = $urandom();
                    cur_bin = 1'($urandom_range(0, 1));
                end
                mv = {mv[2:0], in_valid};
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("s_recv_count", recv, 16);
        check("s_sent_count", sent, 16);

        // Mid-stream reset: three beats in flight, reset competes with a new
        // beat, nothing may emerge afterwards.
        #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            A = 32'h100 + 32'(i); B = 32'h1; Bin = 1'b0;
            @(posedge clk); #1;
        end
        check("fill_no_out", out_valid, 0);
        rst = 1'b1;
        in_valid = 1'b1; A = 32'h99; B = 32'h1; Bin = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("flush_no_stale", out_valid, 0);
        end
        run_one("post_rst", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
